// File: rtl/priority_scanner.sv
// Sequential priority scanner: accepts an N-bit request vector and emits
// each set index, MSB first. Optional out_remaining: PRIORITY_SCANNER_POPCOUNT_EN.
module priority_scanner #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         in_zero,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last,
`ifdef PRIORITY_SCANNER_POPCOUNT_EN
  output logic [W:0]   out_remaining,
`endif
  output logic         busy
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic         in_zero_q, in_zero_d;

  logic [W-1:0] top_idx;
  logic         one_left;
  logic         in_fire;
  logic         out_fire;

  // Highest set bit of pending wins; pending = 0 decodes to index 0.
  always_comb begin
    top_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (pending_q[i]) top_idx = W'(i);
    end
  end

  assign one_left = (pending_q != '0) &&
                    ((pending_q & (pending_q - N'(1))) == '0);

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == SCAN);
  assign busy      = (state_q == SCAN);
  assign out_idx   = top_idx;
  assign out_last  = out_valid && one_left;
  assign in_zero   = in_zero_q;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    in_zero_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_fire) begin
          if (in_data == '0) begin
            in_zero_d = 1'b1;
          end else begin
            pending_d = in_data;
            state_d   = SCAN;
          end
        end
      end
      SCAN: begin
        if (out_fire) begin
          pending_d = pending_q & ~(N'(1) << top_idx);
          if (one_left) state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      in_zero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      in_zero_q <= in_zero_d;
    end
  end

`ifdef PRIORITY_SCANNER_POPCOUNT_EN
  logic [W:0] pop_cnt;

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < N; i++) begin
      pop_cnt = pop_cnt + (W+1)'(pending_q[i]);
    end
  end

  assign out_remaining = pop_cnt;
`endif

endmodule

// File: tb/tb_priority_scanner.sv
// Directed bench for priority_scanner: N=8 and N=16 instances,
// hand-computed expected index sequences.
module tb_priority_scanner;

  logic        clk;
  logic        rst;

  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_zero;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_idx;
  logic        out_last;
  logic        busy;

  logic        in_valid16;
  logic        in_ready16;
  logic [15:0] in_data16;
  logic        in_zero16;
  logic        out_valid16;
  logic        out_ready16;
  logic [3:0]  out_idx16;
  logic        out_last16;
  logic        busy16;

`ifdef PRIORITY_SCANNER_POPCOUNT_EN
  logic [3:0]  out_rem;
  logic [4:0]  out_rem16;
`endif

  int n_checks;
  int n_pass;

  priority_scanner #(.N(8)) u_dut8 (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_zero      (in_zero),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_idx      (out_idx),
    .out_last     (out_last),
`ifdef PRIORITY_SCANNER_POPCOUNT_EN
    .out_remaining(out_rem),
`endif
    .busy         (busy)
  );

  priority_scanner #(.N(16)) u_dut16 (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid16),
    .in_ready     (in_ready16),
    .in_data      (in_data16),
    .in_zero      (in_zero16),
    .out_valid    (out_valid16),
    .out_ready    (out_ready16),
    .out_idx      (out_idx16),
    .out_last     (out_last16),
`ifdef PRIORITY_SCANNER_POPCOUNT_EN
    .out_remaining(out_rem16),
`endif
    .busy         (busy16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  int exp_idx;
  int guard;
  logic rdy;

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b0;
    in_valid16  = 1'b0;
    in_data16   = '0;
    out_ready16 = 1'b0;
    nxt();
    nxt();
    check("rst_valid_hi", 32'(out_valid), 0);
    rst = 1'b0;
    nxt();

    // reset state
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_idx", 32'(out_idx), 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_in_zero", 32'(in_zero), 0);
    check("rst_busy", 32'(busy), 0);
`ifdef PRIORITY_SCANNER_POPCOUNT_EN
    check("rst_remaining", 32'(out_rem), 0);
`endif

    // 8'b1010_0110 with out_ready held high: 7,5,2,1
    in_valid  = 1'b1;
    in_data   = 8'hA6;
    out_ready = 1'b1;
    nxt();
    in_valid = 1'b0;
    check("a6_valid", 32'(out_valid), 1);
    check("a6_busy", 32'(busy), 1);
    check("a6_in_ready", 32'(in_ready), 0);
    check("a6_idx0", 32'(out_idx), 7);
    check("a6_last0", 32'(out_last), 0);
`ifdef PRIORITY_SCANNER_POPCOUNT_EN
    check("a6_rem0", 32'(out_rem), 4);
`endif
    nxt();
    check("a6_idx1", 32'(out_idx), 5);
    check("a6_last1", 32'(out_last), 0);
`ifdef PRIORITY_SCANNER_POPCOUNT_EN
    check("a6_rem1", 32'(out_rem), 3);
`endif
    nxt();
    check("a6_idx2", 32'(out_idx), 2);
    check("a6_last2", 32'(out_last), 0);
`ifdef PRIORITY_SCANNER_POPCOUNT_EN
    check("a6_rem2", 32'(out_rem), 2);
`endif
    nxt();
    check("a6_idx3", 32'(out_idx), 1);
    check("a6_last3", 32'(out_last), 1);
    check("a6_valid3", 32'(out_valid), 1);
`ifdef PRIORITY_SCANNER_POPCOUNT_EN
    check("a6_rem3", 32'(out_rem), 1);
`endif
    nxt();
    check("a6_done_valid", 32'(out_valid), 0);
    check("a6_done_ready", 32'(in_ready), 1);
    check("a6_done_busy", 32'(busy), 0);
`ifdef PRIORITY_SCANNER_POPCOUNT_EN
    check("a6_done_rem", 32'(out_rem), 0);
`endif

    // all-zero vector
    in_valid = 1'b1;
    in_data  = 8'h00;
    nxt();
    in_valid = 1'b0;
    check("zero_pulse", 32'(in_zero), 1);
    check("zero_valid", 32'(out_valid), 0);
    check("zero_ready", 32'(in_ready), 1);
    nxt();
    check("zero_pulse_end", 32'(in_zero), 0);
    check("zero_valid2", 32'(out_valid), 0);

    // bit 0 only
    in_valid = 1'b1;
    in_data  = 8'h01;
    nxt();
    in_valid = 1'b0;
    check("b0_valid", 32'(out_valid), 1);
    check("b0_idx", 32'(out_idx), 0);
    check("b0_last", 32'(out_last), 1);
`ifdef PRIORITY_SCANNER_POPCOUNT_EN
    check("b0_rem", 32'(out_rem), 1);
`endif
    nxt();
    check("b0_done", 32'(out_valid), 0);
    check("b0_zero", 32'(in_zero), 0);

    // 8'hFF with back-pressure, then toggled out_ready
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    nxt();
    in_valid = 1'b0;
    check("ff_stall0", 32'(out_idx), 7);
    nxt();
    in_valid = 1'b1;
    in_data  = 8'h80;
    check("ff_stall1", 32'(out_idx), 7);
    check("ff_stall_ready", 32'(in_ready), 0);
    nxt();
    check("ff_stall2", 32'(out_idx), 7);
    check("ff_stall_last", 32'(out_last), 0);
    exp_idx = 7;
    guard   = 0;
    while (exp_idx >= 0 && guard < 40) begin
      rdy = (guard % 2 == 0);
      check("ff_seq_valid", 32'(out_valid), 1);
      check("ff_seq_idx", 32'(out_idx), 32'(exp_idx));
      check("ff_seq_last", 32'(out_last), 32'(exp_idx == 0));
`ifdef PRIORITY_SCANNER_POPCOUNT_EN
      check("ff_seq_rem", 32'(out_rem), 32'(exp_idx + 1));
`endif
      out_ready = rdy;
      nxt();
      if (rdy) exp_idx--;
      guard++;
    end
    check("ff_seq_bound", 32'(exp_idx), 32'(-1));
    out_ready = 1'b0;
    check("ff_end_valid", 32'(out_valid), 0);
    check("ff_end_ready", 32'(in_ready), 1);
    nxt();
    in_valid = 1'b0;
    check("h80_valid", 32'(out_valid), 1);
    check("h80_idx", 32'(out_idx), 7);
    check("h80_last", 32'(out_last), 1);
    out_ready = 1'b1;
    nxt();
    check("h80_done", 32'(out_valid), 0);

    // reset mid-scan after one beat
    in_valid = 1'b1;
    in_data  = 8'hA6;
    nxt();
    in_valid = 1'b0;
    check("mid_idx0", 32'(out_idx), 7);
    nxt();
    check("mid_idx1", 32'(out_idx), 5);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 0);
    nxt();
    check("mid_rst_valid2", 32'(out_valid), 0);
    rst = 1'b0;
    nxt();
    check("mid_rel_ready", 32'(in_ready), 1);
    check("mid_rel_valid", 32'(out_valid), 0);
    check("mid_rel_busy", 32'(busy), 0);
    nxt();
    check("mid_rel_valid2", 32'(out_valid), 0);
    out_ready = 1'b0;

    // N=16 instance, 16'h8001
    out_ready16 = 1'b1;
    in_valid16  = 1'b1;
    in_data16   = 16'h8001;
    nxt();
    in_valid16 = 1'b0;
    check("n16_valid0", 32'(out_valid16), 1);
    check("n16_idx0", 32'(out_idx16), 15);
    check("n16_last0", 32'(out_last16), 0);
`ifdef PRIORITY_SCANNER_POPCOUNT_EN
    check("n16_rem0", 32'(out_rem16), 2);
`endif
    nxt();
    check("n16_idx1", 32'(out_idx16), 0);
    check("n16_last1", 32'(out_last16), 1);
`ifdef PRIORITY_SCANNER_POPCOUNT_EN
    check("n16_rem1", 32'(out_rem16), 1);
`endif
    nxt();
    check("n16_done", 32'(out_valid16), 0);
    check("n16_ready", 32'(in_ready16), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
